vga_sync_gen: RTL and testbench

- Sits directly downstream of the horizontal/vertical VGA pixel counters.
- Decodes the counter pair (h 0..799, v 0..524) into registered sync/blank/coordinate signals for the 640x480@60 raster, aligned by a configurable pipeline delay.
- Also tracks counter continuity with a lock FSM so the display path can suppress output until timing is stable.

---
 rtl/vga_sync_gen.sv | 238 +++++++++++++++++++++++
 tb/tb_vga_sync_gen.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA sync generator: decodes the h/v counter pair into delayed sync, blank and
// coordinate outputs, and monitors counter continuity. Define VGA_FRAME_COUNT_EN to add frame_cnt.
module vga_sync_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       video_on,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       line_start,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACTIVE_C = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACTIVE_C = 10'(V_ACTIVE);
  localparam logic [9:0] H_TOTAL_C  = 10'(H_TOTAL);
  localparam logic [9:0] V_TOTAL_C  = 10'(V_TOTAL);
  localparam logic [9:0] H_LAST_C   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST_C   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START_C = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END_C   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START_C = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END_C   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic       hs_n;
    logic       vs_n;
    logic       vid;
    logic [9:0] x;
    logic [8:0] y;
    logic       ls;
    logic       fs;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, vid: 1'b0, x: 10'd0,
                                    y: 9'd0, ls: 1'b0, fs: 1'b0};

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  stage_t     dec_s;
  stage_t     pipe_r [PIPE_DELAY];
  logic       in_range_s;
  state_t     state_r;
  state_t     state_nxt_s;
  logic [9:0] h_prev_r;
  logic [9:0] v_prev_r;
  logic [9:0] h_exp_s;
  logic [9:0] v_exp_s;
  logic       match_s;
  logic       at_origin_s;
  logic       at_end_s;
  logic       err_set_s;
  logic       locked_r;
  logic       sync_err_r;

  assign in_range_s = (h_count < H_TOTAL_C) && (v_count < V_TOTAL_C);

  // Stage-0 decode; anything outside the raster decodes as idle.
  always_comb begin
    dec_s = STAGE_IDLE;
    if (in_range_s) begin
      dec_s.hs_n = ~((h_count >= HS_START_C) && (h_count < HS_END_C));
      dec_s.vs_n = ~((v_count >= VS_START_C) && (v_count < VS_END_C));
      if ((h_count < H_ACTIVE_C) && (v_count < V_ACTIVE_C)) begin
        dec_s.vid = 1'b1;
        dec_s.x   = h_count;
        dec_s.y   = v_count[8:0];
      end else begin
        dec_s.vid = 1'b0;
        dec_s.x   = 10'd0;
        dec_s.y   = 9'd0;
      end
      dec_s.ls = (h_count == 10'd0);
      dec_s.fs = (h_count == 10'd0) && (v_count == 10'd0);
    end else begin
      dec_s = STAGE_IDLE;
    end
  end

  // Delay line; the last stage drops its pulses on disabled edges so they stay one cycle wide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        pipe_r[i] <= STAGE_IDLE;
      end
    end else if (en) begin
      pipe_r[0] <= dec_s;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end else begin
      pipe_r[PIPE_DELAY-1].ls <= 1'b0;
      pipe_r[PIPE_DELAY-1].fs <= 1'b0;
    end
  end

  assign hsync_n     = pipe_r[PIPE_DELAY-1].hs_n;
  assign vsync_n     = pipe_r[PIPE_DELAY-1].vs_n;
  assign video_on    = pipe_r[PIPE_DELAY-1].vid;
  assign x           = pipe_r[PIPE_DELAY-1].x;
  assign y           = pipe_r[PIPE_DELAY-1].y;
  assign line_start  = pipe_r[PIPE_DELAY-1].ls;
  assign frame_start = pipe_r[PIPE_DELAY-1].fs;

  // Successor of the previously sampled pair.
  always_comb begin
    h_exp_s = h_prev_r + 10'd1;
    v_exp_s = v_prev_r;
    if (h_prev_r == H_LAST_C) begin
      h_exp_s = 10'd0;
      if (v_prev_r == V_LAST_C) begin
        v_exp_s = 10'd0;
      end else begin
        v_exp_s = v_prev_r + 10'd1;
      end
    end else begin
      h_exp_s = h_prev_r + 10'd1;
      v_exp_s = v_prev_r;
    end
  end

  assign match_s     = (h_count == h_exp_s) && (v_count == v_exp_s);
  assign at_origin_s = (h_count == 10'd0) && (v_count == 10'd0);
  assign at_end_s    = (h_count == H_LAST_C) && (v_count == V_LAST_C);

  // Lock FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    err_set_s   = 1'b0;
    case (state_r)
      SEARCH: begin
        if (at_origin_s) begin
          state_nxt_s = TRACK;
        end else begin
          state_nxt_s = SEARCH;
        end
      end
      TRACK: begin
        if (!match_s) begin
          state_nxt_s = SEARCH;
        end else if (at_end_s) begin
          state_nxt_s = LOCKED;
        end else begin
          state_nxt_s = TRACK;
        end
      end
      LOCKED: begin
        if (!match_s) begin
          state_nxt_s = SEARCH;
          err_set_s   = 1'b1;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: begin
        state_nxt_s = SEARCH;
      end
    endcase
  end

  // Lock FSM state, last sampled pair and the registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= SEARCH;
      h_prev_r   <= 10'd0;
      v_prev_r   <= 10'd0;
      locked_r   <= 1'b0;
      sync_err_r <= 1'b0;
    end else if (en) begin
      state_r    <= state_nxt_s;
      h_prev_r   <= h_count;
      v_prev_r   <= v_count;
      locked_r   <= (state_nxt_s == LOCKED);
      sync_err_r <= sync_err_r | err_set_s;
    end else begin
      state_r    <= state_r;
      h_prev_r   <= h_prev_r;
      v_prev_r   <= v_prev_r;
      locked_r   <= locked_r;
      sync_err_r <= sync_err_r;
    end
  end

  assign locked   = locked_r;
  assign sync_err = sync_err_r;

`ifdef VGA_FRAME_COUNT_EN
  logic        locked_d_r;
  logic [15:0] frame_cnt_r;

  // Frame counter; restarts from zero whenever lock is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_d_r  <= 1'b0;
      frame_cnt_r <= 16'd0;
    end else begin
      locked_d_r <= locked_r;
      if (locked_d_r && !locked_r) begin
        frame_cnt_r <= 16'd0;
      end else if (pipe_r[PIPE_DELAY-1].fs) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

  assign frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen on a reduced raster (40x20 totals) so whole
// frames stay short; a scoreboard queue carries the expected decode through the pipeline.
module tb_vga_sync_gen;

  localparam int HA = 24;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 4;
  localparam int VA = 12;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 4;
  localparam int PD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct packed {
    logic       hs_n;
    logic       vs_n;
    logic       vid;
    logic [9:0] x;
    logic [8:0] y;
    logic       ls;
    logic       fs;
  } exp_t;

  localparam exp_t IDLE_E = '{hs_n: 1'b1, vs_n: 1'b1, vid: 1'b0, x: 10'd0,
                              y: 9'd0, ls: 1'b0, fs: 1'b0};

  logic       clk;
  logic       reset;
  logic       en;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       hsync_n;
  logic       vsync_n;
  logic       video_on;
  logic [9:0] x;
  logic [8:0] y;
  logic       line_start;
  logic       frame_start;
  logic       locked;
  logic       sync_err;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_cnt;
`endif

  int   n_checks;
  int   n_errors;
  exp_t exp_q [$];
  exp_t cur_exp;
  int   ls_cnt;
  int   fs_cnt;
  int   hs_run;
  int   hs_runs;
  int   hs_bad;

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIPE_DELAY(PD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .h_count(h_count),
    .v_count(v_count),
    .hsync_n(hsync_n),
    .vsync_n(vsync_n),
    .video_on(video_on),
    .x(x),
    .y(y),
    .line_start(line_start),
    .frame_start(frame_start),
    .locked(locked),
`ifdef VGA_FRAME_COUNT_EN
    .frame_cnt(frame_cnt),
`endif
    .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  function automatic exp_t model(input logic [9:0] h, input logic [9:0] v);
    exp_t r;
    int hi;
    int vi;
    hi = int'(h);
    vi = int'(v);
    r = IDLE_E;
    if (hi < HT && vi < VT) begin
      r.hs_n = !(hi >= HA + HF && hi < HA + HF + HS);
      r.vs_n = !(vi >= VA + VF && vi < VA + VF + VS);
      if (hi < HA && vi < VA) begin
        r.vid = 1'b1;
        r.x   = h;
        r.y   = v[8:0];
      end
      r.ls = (hi == 0);
      r.fs = (hi == 0 && vi == 0);
    end
    return r;
  endfunction

  task automatic init_sb();
    exp_q.delete();
    for (int i = 0; i < PD - 1; i++) exp_q.push_back(IDLE_E);
    cur_exp = IDLE_E;
  endtask

  task automatic clear_stats();
    ls_cnt  = 0;
    fs_cnt  = 0;
    hs_run  = 0;
    hs_runs = 0;
    hs_bad  = 0;
  endtask

  task automatic drive_cycle(input logic [9:0] h, input logic [9:0] v, input logic e);
    exp_t got;
    h_count = h;
    v_count = v;
    en      = e;
    @(posedge clk);
    #1;
    if (e) begin
      exp_q.push_back(model(h, v));
      cur_exp = exp_q.pop_front();
    end else begin
      cur_exp.ls = 1'b0;
      cur_exp.fs = 1'b0;
    end
    got = '{hs_n: hsync_n, vs_n: vsync_n, vid: video_on, x: x, y: y,
            ls: line_start, fs: frame_start};
    n_checks++;
    if (got !== cur_exp) begin
      n_errors++;
      $display("FAIL pipe_out h=%0d v=%0d en=%0b: got=%h required=%h (hs_n,vs_n,vid,x,y,ls,fs)",
               h, v, e, got, cur_exp);
    end
    if (line_start === 1'b1) ls_cnt++;
    if (frame_start === 1'b1) fs_cnt++;
    if (hsync_n === 1'b0) begin
      hs_run++;
    end else if (hs_run != 0) begin
      hs_runs++;
      if (hs_run != HS) hs_bad++;
      hs_run = 0;
    end
  endtask

  task automatic run_to_end(input int h0, input int v0, input bit stop_before_last);
    int h_start;
    h_start = h0;
    for (int v = v0; v < VT; v++) begin
      for (int h = h_start; h < HT; h++) begin
        if (!(stop_before_last && v == VT - 1 && h == HT - 1))
          drive_cycle(10'(h), 10'(v), 1'b1);
      end
      h_start = 0;
    end
  endtask

  task automatic test_reset();
    logic [25:0] got;
    logic [25:0] req;
    reset   = 1'b1;
    en      = 1'b0;
    h_count = 10'd0;
    v_count = 10'd0;
    #2;
    req = {1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    got = {hsync_n, vsync_n, video_on, x, y, line_start, frame_start, locked, sync_err};
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL reset_state: got=%h required=%h", got, req);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    init_sb();
    clear_stats();
  endtask

  task automatic test_frame_lock();
    run_to_end(0, 0, 1'b1);
    n_checks++;
    if (locked !== 1'b0) begin
      n_errors++;
      $display("FAIL lock_early: locked=%0b required=0", locked);
    end
    drive_cycle(10'(HT - 1), 10'(VT - 1), 1'b1);
    n_checks++;
    if (locked !== 1'b1 || sync_err !== 1'b0) begin
      n_errors++;
      $display("FAIL lock_rise: locked=%0b sync_err=%0b required 1/0", locked, sync_err);
    end
    clear_stats();
    run_to_end(0, 0, 1'b0);
    n_checks++;
    if (ls_cnt != VT) begin
      n_errors++;
      $display("FAIL line_start_count: got=%0d required=%0d", ls_cnt, VT);
    end
    n_checks++;
    if (fs_cnt != 1) begin
      n_errors++;
      $display("FAIL frame_start_count: got=%0d required=1", fs_cnt);
    end
    n_checks++;
    if (hs_runs != VT || hs_bad != 0) begin
      n_errors++;
      $display("FAIL hsync_width: runs=%0d bad=%0d required runs=%0d bad=0", hs_runs, hs_bad, VT);
    end
    n_checks++;
    if (locked !== 1'b1) begin
      n_errors++;
      $display("FAIL lock_hold: locked=%0b required=1", locked);
    end
  endtask

  task automatic test_discontinuity();
    for (int h = 0; h <= 10; h++) drive_cycle(10'(h), 10'd0, 1'b1);
    n_checks++;
    if (locked !== 1'b1 || sync_err !== 1'b0) begin
      n_errors++;
      $display("FAIL disc_before: locked=%0b sync_err=%0b required 1/0", locked, sync_err);
    end
    drive_cycle(10'd15, 10'd0, 1'b1);
    n_checks++;
    if (locked !== 1'b0 || sync_err !== 1'b1) begin
      n_errors++;
      $display("FAIL disc_detect: locked=%0b sync_err=%0b required 0/1", locked, sync_err);
    end
    run_to_end(16, 0, 1'b0);
    run_to_end(0, 0, 1'b1);
    n_checks++;
    if (locked !== 1'b0) begin
      n_errors++;
      $display("FAIL relock_early: locked=%0b required=0", locked);
    end
    drive_cycle(10'(HT - 1), 10'(VT - 1), 1'b1);
    n_checks++;
    if (locked !== 1'b1 || sync_err !== 1'b1) begin
      n_errors++;
      $display("FAIL relock: locked=%0b sync_err=%0b required 1/1", locked, sync_err);
    end
  endtask

  task automatic test_enable_toggle();
    clear_stats();
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        drive_cycle(10'(h), 10'(v), 1'b1);
        drive_cycle(10'(HT + 5), 10'(VT + 5), 1'b0);
      end
    end
    n_checks++;
    if (ls_cnt != VT || fs_cnt != 1) begin
      n_errors++;
      $display("FAIL toggle_pulses: line=%0d frame=%0d required %0d/1", ls_cnt, fs_cnt, VT);
    end
    n_checks++;
    if (locked !== 1'b1) begin
      n_errors++;
      $display("FAIL toggle_lock: locked=%0b required=1", locked);
    end
  endtask

  task automatic test_reset_midline();
    logic [25:0] got;
    logic [25:0] req;
    for (int v = 0; v < 5; v++) begin
      for (int h = 0; h < HT; h++) drive_cycle(10'(h), 10'(v), 1'b1);
    end
    for (int h = 0; h <= HA / 2; h++) drive_cycle(10'(h), 10'd5, 1'b1);
    n_checks++;
    if (locked !== 1'b1 || video_on !== 1'b1) begin
      n_errors++;
      $display("FAIL midline_pre: locked=%0b video_on=%0b required 1/1", locked, video_on);
    end
    #2;
    reset = 1'b1;
    #1;
    req = {1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    got = {hsync_n, vsync_n, video_on, x, y, line_start, frame_start, locked, sync_err};
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL midline_reset: got=%h required=%h", got, req);
    end
    #2;
    reset = 1'b0;
    init_sb();
  endtask

  task automatic test_out_of_range();
    run_to_end(0, 0, 1'b0);
    n_checks++;
    if (locked !== 1'b1 || sync_err !== 1'b0) begin
      n_errors++;
      $display("FAIL oor_pre: locked=%0b sync_err=%0b required 1/0", locked, sync_err);
    end
    drive_cycle(10'd0, 10'd0, 1'b1);
    drive_cycle(10'd1, 10'd0, 1'b1);
    drive_cycle(10'd900, 10'd600, 1'b1);
    n_checks++;
    if (locked !== 1'b0 || sync_err !== 1'b1) begin
      n_errors++;
      $display("FAIL oor_fsm: locked=%0b sync_err=%0b required 0/1", locked, sync_err);
    end
    drive_cycle(10'(HA + HF), 10'd600, 1'b1);
    n_checks++;
    if (hsync_n !== 1'b1 || vsync_n !== 1'b1 || video_on !== 1'b0 || x !== 10'd0 || y !== 9'd0) begin
      n_errors++;
      $display("FAIL oor_decode: hs_n=%0b vs_n=%0b vid=%0b x=%0d y=%0d required 1/1/0/0/0",
               hsync_n, vsync_n, video_on, x, y);
    end
    drive_cycle(10'd5, 10'(VT), 1'b1);
    drive_cycle(10'd6, 10'(VT), 1'b1);
  endtask

`ifdef VGA_FRAME_COUNT_EN
  task automatic test_frame_count();
    #2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    init_sb();
    for (int f = 0; f < 3; f++) run_to_end(0, 0, 1'b0);
    n_checks++;
    if (frame_cnt !== 16'd3) begin
      n_errors++;
      $display("FAIL frame_cnt_3: got=%0d required=3", frame_cnt);
    end
    drive_cycle(10'd0, 10'd0, 1'b1);
    drive_cycle(10'd1, 10'd0, 1'b1);
    drive_cycle(10'd7, 10'd0, 1'b1);
    drive_cycle(10'd8, 10'd0, 1'b1);
    drive_cycle(10'd9, 10'd0, 1'b1);
    n_checks++;
    if (frame_cnt !== 16'd0 || locked !== 1'b0) begin
      n_errors++;
      $display("FAIL frame_cnt_clear: got=%0d locked=%0b required 0/0", frame_cnt, locked);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_frame_lock();
    test_discontinuity();
    test_enable_toggle();
    test_reset_midline();
    test_out_of_range();
`ifdef VGA_FRAME_COUNT_EN
    test_frame_count();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
